uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Parametrised UART transmitter that integrates the control FSM, baud-period counter, shift/bit counter, parity generator and output mux in one block.
- Generalises the fixed 8-bit, one-bit-per-clock transmitter to configurable data width, clocks-per-bit, parity type (even/odd) and 1 or 2 stop bits.
- Sits between the system-side data source and the serial TX pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..16.
- CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range >= 1. The baud counter width is derived from this value.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset; synchronous, active-low.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
- Data_Valid  input  1  request to transmit P_DATA; honoured only in IDLE.
- PAR_EN  input  1  parity bit enable; sampled on acceptance.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- STOP2  input  1  0 = one stop bit, 1 = two stop bits; sampled on acceptance.
- TX_OUT  output  1  serial line, registered; idle = 1.
- busy  output  1  registered; high from acceptance through the last stop-bit cycle.
- tx_done  output  1  registered one-cycle pulse on frame completion.

Behaviour:
- Reset (RST low at a rising edge): next state IDLE; TX_OUT=1, busy=0, tx_done=0; baud and bit counters cleared. This applies mid-frame: the frame is aborted, nothing is resumed, and no tx_done pulse is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus BREAK when the optional feature is compiled in). Encoding is free.
- Acceptance: at an edge where state=IDLE and Data_Valid=1:
  - P_DATA, PAR_EN, PAR_TYP and STOP2 are latched into internal registers.
  - Parity bit is latched as XOR(P_DATA) ^ PAR_TYP.
  - State goes to START; TX_OUT=0 and busy=1 from that edge.
  - Changes on any input after acceptance have no effect on the frame in flight.
- Bit timing: every bit (start, data, parity, stop) holds TX_OUT for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1, then the counter wraps to 0.
  - CLKS_PER_BIT=1 gives one bit per clock.
- START -> DATA after one bit period.
- DATA: data bits are sent LSB first. The bit counter runs 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 completes, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = latched parity bit for one bit period, then STOP.
- STOP: TX_OUT=1 for one bit period (STOP2=0) or two bit periods (STOP2=1), then IDLE.
  - On the edge entering IDLE: busy=0 and tx_done=1 for exactly one cycle.
- Frame length: busy stays high for (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) * CLKS_PER_BIT cycles.
- Back-to-back frames: Data_Valid is evaluated in IDLE. There is a minimum of one IDLE cycle (TX_OUT=1, busy=0) between frames. If Data_Valid is held high, the next frame starts on the edge after tx_done.
- Data_Valid=1 while busy=1 is ignored: no queueing, no error flag.
- TX_OUT is always driven from a register, so it is glitch-free.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input BRK_REQ (1 bit) and state BREAK.
  - In IDLE, BRK_REQ=1 takes priority over Data_Valid.
  - The FSM enters BREAK: TX_OUT=0 and busy=1.
  - BREAK holds for at least (DATA_WIDTH+2)*CLKS_PER_BIT cycles and continues while BRK_REQ stays high. When both conditions are met, the FSM enters STOP and sends one stop-bit period (forced STOP2=0), then IDLE with a tx_done pulse.
  - Reset during BREAK returns to IDLE immediately.
- When undefined: no BRK_REQ port and no BREAK state; behaviour is exactly as above.

Test Plan:
- Even parity: DATA_WIDTH=8, CLKS_PER_BIT=4, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity bit 0), each bit held 4 cycles; busy high 44 cycles; one tx_done pulse.
- Odd parity, two stop bits: same data with PAR_TYP=1, STOP2=1 -> parity bit 1, two stop bits; busy high 48 cycles.
- No parity, two stop bits: PAR_EN=0, STOP2=1, DATA_WIDTH=8, CLKS_PER_BIT=1, P_DATA=0x3C -> 0,0,0,1,1,1,1,0,0,1,1 over 11 cycles. Data_Valid held high -> one idle cycle, then a second frame.
- Ignore while busy: pulse Data_Valid with P_DATA=0xFF mid-frame of 0x00 -> transmitted data remains 0x00; no extra frame follows.
- Reset mid-frame: RST=0 for one edge during data bit 3 -> next cycle TX_OUT=1, busy=0, no tx_done; a following Data_Valid starts a clean frame.
- Break (UART_TX_BREAK_EN defined): BRK_REQ pulsed one cycle, CLKS_PER_BIT=2, DATA_WIDTH=8 -> TX_OUT low 20 cycles, high 2 cycles, then tx_done.

Source files
------------

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - parametrised UART transmitter (FSM, baud counter, shifter, parity, output register)
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-low reset
//   P_DATA      parallel payload, latched on acceptance
//   Data_Valid  transmit request, honoured only in IDLE
//   PAR_EN      parity enable, latched on acceptance
//   PAR_TYP     0 = even, 1 = odd parity, latched on acceptance
//   STOP2       0 = one stop bit, 1 = two stop bits, latched on acceptance
//   BRK_REQ     break request (only with UART_TX_BREAK_EN)
//   TX_OUT      registered serial line, idles high
//   busy        registered, high from acceptance through the last stop-bit cycle
//   tx_done     registered one-cycle pulse on frame completion
//
// Optional feature macro: UART_TX_BREAK_EN (adds BRK_REQ and the BREAK state).
module uart_tx_core #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BRK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // bit counter also measures the break length, so it must reach DATA_WIDTH+2
  localparam int BW = $clog2(DATA_WIDTH + 3);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [BW-1:0] BRK_LAST = BW'(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BRK_SAT  = BW'(DATA_WIDTH + 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_TX_BREAK_EN
    S_STOP,
    S_BREAK
`else
    S_STOP
`endif
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         baud_cnt, baud_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic                  par_en_q, par_q, stop2_q;
  logic                  tx_n, done_n, bit_end, brk_go, accept;

`ifdef UART_TX_BREAK_EN
  assign brk_go = BRK_REQ;
`else
  assign brk_go = 1'b0;
`endif

  // break request wins over a data request in IDLE
  assign accept  = (state == S_IDLE) && Data_Valid && !brk_go;
  assign bit_end = (baud_cnt == BAUD_MAX);

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + CW'(1);
    bit_n   = bit_cnt;
    shift_n = shift_q;
    tx_n    = TX_OUT;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (BRK_REQ) begin
          state_n = S_BREAK;
          tx_n    = 1'b0;
        end
`endif
        if (accept) begin
          state_n = S_START;
          tx_n    = 1'b0;
          shift_n = P_DATA;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            bit_n = '0;
            if (par_en_q) begin
              state_n = S_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            // shift_q[0] is on the line; the next bit is shift_q[1]
            bit_n   = bit_cnt + BW'(1);
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == {{(BW-1){1'b0}}, stop2_q}) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        tx_n = 1'b0;
        if (bit_cnt == BRK_SAT) begin
          // minimum length already met: leave as soon as the request drops
          baud_n = '0;
          if (!BRK_REQ) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
            bit_n   = '0;
          end
        end else if (bit_end) begin
          if (bit_cnt == BRK_LAST && !BRK_REQ) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      TX_OUT   <= tx_n;
      busy     <= (state_n != S_IDLE);
      tx_done  <= done_n;
      if (accept) begin
        par_en_q <= PAR_EN;
        par_q    <= (^P_DATA) ^ PAR_TYP;
        stop2_q  <= STOP2;
      end
      // a break always ends with a single stop bit
      if ((state == S_IDLE) && brk_go) begin
        stop2_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       par_en, par_typ, stop2;
  logic       dv4, dv1;
  logic       tx4, busy4, done4;
  logic       tx1, busy1, done1;
  logic       sel;
  logic       tx_s, busy_s, done_s;

  always #5 clk = ~clk;

  uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv4),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
`ifdef UART_TX_BREAK_EN
    .BRK_REQ(1'b0),
`endif
    .TX_OUT(tx4), .busy(busy4), .tx_done(done4)
  );

  uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv1),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
`ifdef UART_TX_BREAK_EN
    .BRK_REQ(1'b0),
`endif
    .TX_OUT(tx1), .busy(busy1), .tx_done(done1)
  );

`ifdef UART_TX_BREAK_EN
  logic brk, tx2, busy2, done2;
  uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut2 (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(1'b0),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .BRK_REQ(brk),
    .TX_OUT(tx2), .busy(busy2), .tx_done(done2)
  );
`endif

  assign tx_s   = sel ? tx1   : tx4;
  assign busy_s = sel ? busy1 : busy4;
  assign done_s = sel ? done1 : done4;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic trace[0:255];
  logic exp_bits[0:15];
  int   len, dones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // record TX_OUT while busy; optionally pulse dv4 with 0xFF mid-frame
  task automatic capture(input int inject_at);
    len   = 0;
    dones = 0;
    while (busy_s && len < 256) begin
      trace[len] = tx_s;
      if (done_s) dones++;
      if (inject_at >= 0 && len == inject_at) begin
        p_data = 8'hFF;
        dv4    = 1'b1;
      end else if (inject_at >= 0 && len == inject_at + 1) begin
        dv4 = 1'b0;
      end
      len++;
      step();
    end
  endtask

  task automatic set_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic s2);
    int n;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
    n = 9;
    if (pe) begin
      exp_bits[n] = pbit;
      n++;
    end
    exp_bits[n] = 1'b1;
    if (s2) exp_bits[n+1] = 1'b1;
  endtask

  task automatic verify(input string name, input int nbits, input int cpb);
    logic [31:0] vec, mask;
    check({name, "_busy_len"}, len, nbits * cpb);
    check({name, "_done_in_frame"}, dones, 0);
    mask = (32'd1 << cpb) - 1;
    for (int i = 0; i < nbits; i++) begin
      vec = '0;
      for (int j = 0; j < cpb; j++) vec[j] = trace[i*cpb + j];
      check($sformatf("%s_bit%0d", name, i), vec, exp_bits[i] ? mask : 32'd0);
    end
    check({name, "_done_pulse"}, done_s, 1'b1);
    check({name, "_idle_tx"}, tx_s, 1'b1);
  endtask

  initial begin
    rst = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    dv4 = 1'b0; dv1 = 1'b0; sel = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    step(); step();
    rst = 1'b1;
    step();
    check("rst_tx", tx4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_tx1", tx1, 1'b1);

    // even parity, one stop bit
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv4 = 1'b1;
    step();
    dv4 = 1'b0;
    capture(-1);
    set_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    verify("even", 11, 4);
    step();
    check("even_done_one_cycle", done4, 1'b0);

    // odd parity, two stop bits
    par_typ = 1'b1; stop2 = 1'b1; dv4 = 1'b1;
    step();
    dv4 = 1'b0; par_en = 1'b0; stop2 = 1'b0;
    capture(-1);
    set_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    verify("odd2", 12, 4);
    step();

    // CLKS_PER_BIT=1, no parity, two stop bits, Data_Valid held high
    sel = 1'b1;
    p_data = 8'h3C; par_en = 1'b0; stop2 = 1'b1; dv1 = 1'b1;
    step();
    capture(-1);
    set_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    verify("cpb1_a", 11, 1);
    check("cpb1_gap_busy", busy1, 1'b0);
    step();
    check("cpb1_restart_busy", busy1, 1'b1);
    check("cpb1_restart_tx", tx1, 1'b0);
    dv1 = 1'b0;
    capture(-1);
    verify("cpb1_b", 11, 1);
    step();
    sel = 1'b0;

    // Data_Valid while busy is ignored
    p_data = 8'h00; par_en = 1'b0; stop2 = 1'b0; dv4 = 1'b1;
    step();
    dv4 = 1'b0;
    capture(10);
    set_frame(8'h00, 1'b0, 1'b0, 1'b0);
    verify("ignore", 10, 4);
    for (int k = 0; k < 6; k++) step();
    check("ignore_no_extra_frame", busy4, 1'b0);

    // reset during data bit 3
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv4 = 1'b1;
    step();
    dv4 = 1'b0;
    for (int k = 0; k < 17; k++) step();
    check("pre_rst_busy", busy4, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_tx", tx4, 1'b1);
    check("mid_rst_busy", busy4, 1'b0);
    check("mid_rst_done", done4, 1'b0);
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      if (done4 || busy4) dones++;
      step();
    end
    check("post_rst_quiet", dones, 0);
    dv4 = 1'b1;
    step();
    dv4 = 1'b0;
    capture(-1);
    set_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    verify("after_rst", 11, 4);
    step();

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    step();
    brk = 1'b0;
    len = 0;
    while (tx2 == 1'b0 && busy2 && len < 100) begin
      len++;
      step();
    end
    check("brk_low_len", len, 20);
    len = 0;
    while (tx2 == 1'b1 && busy2 && len < 100) begin
      len++;
      step();
    end
    check("brk_high_len", len, 2);
    check("brk_done", done2, 1'b1);
    check("brk_idle_busy", busy2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
